madam_bitreader: RTL and testbench

- Sequential MSB-first bit-stream reader for the MADAM cel/PLUT decoder path.
- Software attaches a byte address, then skips or reads 0..32-bit fields, right-aligned on data_out.
- Fetches 32-bit words on demand from PS memory through a mem_if request/response port. One op at a time, qualified by ap_busy.

---
 rtl/madam_bitreader_if.sv | 40 ++++
 rtl/madam_bitreader.sv | 161 ++++++++++++++++
 tb/tb_madam_bitreader.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/madam_bitreader_if.sv
// -----------------------------------------------------------------------------
// bitreader_pkg : operation encoding shared by the bit reader and its users.
// mem_if        : single-outstanding word request/response memory port.
//   slave  modport (bit reader side): drives req, addr, we, be, wdata;
//                                     samples gnt, rsp_valid, rsp_rdata, rsp_error.
//   master modport (memory side)    : the mirror image.
// -----------------------------------------------------------------------------
package bitreader_pkg;
  typedef enum logic [1:0] {
    BR_ATTACH = 2'd0,
    BR_SKIP   = 2'd1,
    BR_READ   = 2'd2,
    BR_NOP    = 2'd3
  } bitreader_op_e;
endpackage

interface mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    req;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    gnt;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_error;

  modport slave (
    output req, addr, we, be, wdata,
    input  gnt, rsp_valid, rsp_rdata, rsp_error
  );

  modport master (
    input  req, addr, we, be, wdata,
    output gnt, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/madam_bitreader.sv
// -----------------------------------------------------------------------------
// madam_bitreader
//   MSB-first bit-stream reader for the MADAM cel/PLUT decoder path.
//   ATTACH sets the stream origin from a byte address, SKIP advances the bit
//   position, READ returns the next 0..32 bits right-aligned on data_out.
//   Words are fetched on demand (one or two per READ, never prefetched).
//
// Ports
//   aclk, aresetn  clock (rising edge), asynchronous active-low reset
//   memory         mem_if.slave word-fetch port (read-only use)
//   addr_in        byte address for BR_ATTACH
//   bitrate_in     field width for BR_READ (values above 32 read 32 bits)
//   bitskip_in     bit count for BR_SKIP
//   req, op        level request and operation, sampled only when idle
//   ap_busy        high while an operation is in progress
//   data_out       result of the most recent completed BR_READ
// -----------------------------------------------------------------------------
module madam_bitreader
  import bitreader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,  // only 32 is supported
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  mem_if.slave                  memory,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] bitrate_in,
  input  logic [DATA_WIDTH-1:0] bitskip_in,
  input  logic                  req,
  input  bitreader_op_e         op,
  output logic                  ap_busy,
  output logic [DATA_WIDTH-1:0] data_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH0, S_WAIT0, S_FETCH1, S_WAIT1, S_DONE
  } state_e;

  state_e                r_state;
  state_e                w_next;
  logic                  r_busy;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [31:0]           r_bitpos;
  logic [5:0]            r_n;        // clamped field width, 0..32
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_w0;
  logic [31:0]           r_data_out;

  logic [5:0]            w_req_n;
  logic [4:0]            w_off;
  logic                  w_need1;
  logic [31:0]           w_rdata;
  logic [31:0]           w_word0;
  logic [31:0]           w_word1;
  logic [31:0]           w_hi;
  logic [31:0]           w_field;
  logic [31:0]           w_pos_adv;

  assign w_req_n   = (bitrate_in >= 32'd32) ? 6'd32 : bitrate_in[5:0];
  assign w_off     = r_bitpos[4:0];
  assign w_need1   = ({2'b00, w_off} + {1'b0, r_n}) > 7'd32;
  assign w_rdata   = memory.rsp_error ? 32'd0 : memory.rsp_rdata;
  assign w_pos_adv = r_bitpos + {26'd0, r_n};

  // The word arriving this cycle is used directly, so extraction happens on
  // the same edge that enters DONE. w1 is zero when only one word was needed.
  assign w_word0 = (r_state == S_WAIT0) ? w_rdata : r_w0;
  assign w_word1 = (r_state == S_WAIT1) ? w_rdata : 32'd0;
  // Upper half of {w0,w1} << off; a shift by 32 yields 0 when off == 0.
  assign w_hi    = (w_word0 << w_off) | (w_word1 >> (6'd32 - {1'b0, w_off}));
  assign w_field = w_hi >> (6'd32 - r_n);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (req) begin
          if (op == BR_READ && w_req_n != 6'd0) w_next = S_FETCH0;
          else                                  w_next = S_DONE;
        end
      end
      S_FETCH0: if (memory.gnt)       w_next = S_WAIT0;
      S_WAIT0:  if (memory.rsp_valid) w_next = w_need1 ? S_FETCH1 : S_DONE;
      S_FETCH1: if (memory.gnt)       w_next = S_WAIT1;
      S_WAIT1:  if (memory.rsp_valid) w_next = S_DONE;
      S_DONE:                         w_next = S_IDLE;
      default:                        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_base     <= '0;
      r_bitpos   <= '0;
      r_n        <= '0;
      r_addr     <= '0;
      r_w0       <= '0;
      r_data_out <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      unique case (r_state)
        S_IDLE: begin
          if (req) begin
            unique case (op)
              BR_ATTACH: begin
                r_base   <= {addr_in[ADDR_WIDTH-1:2], 2'b00};
                r_bitpos <= {27'd0, addr_in[1:0], 3'b000};
              end
              BR_SKIP: r_bitpos <= r_bitpos + bitskip_in;
              BR_READ: begin
                r_n    <= w_req_n;
                r_addr <= r_base + {3'd0, r_bitpos[31:5], 2'b00};
                if (w_req_n == 6'd0) r_data_out <= '0;
              end
              default: ;
            endcase
          end
        end
        S_WAIT0: begin
          if (memory.rsp_valid) begin
            r_w0 <= w_rdata;
            if (w_need1) begin
              r_addr <= r_addr + 32'd4;
            end else begin
              r_data_out <= w_field;
              r_bitpos   <= w_pos_adv;
            end
          end
        end
        S_WAIT1: begin
          if (memory.rsp_valid) begin
            r_data_out <= w_field;
            r_bitpos   <= w_pos_adv;
          end
        end
        default: ;
      endcase
    end
  end

  // Address is held through FETCH and WAIT so a responder may decode rdata
  // combinationally from it; it reads as zero whenever no access is in flight.
  assign memory.req   = (r_state == S_FETCH0) || (r_state == S_FETCH1);
  assign memory.addr  = (r_state == S_FETCH0 || r_state == S_WAIT0 ||
                         r_state == S_FETCH1 || r_state == S_WAIT1) ? r_addr : '0;
  assign memory.we    = 1'b0;
  assign memory.be    = 4'hF;
  assign memory.wdata = '0;

  assign ap_busy  = r_busy;
  assign data_out = r_data_out;

endmodule

// File: tb/tb_madam_bitreader.sv
// -----------------------------------------------------------------------------
// tb_madam_bitreader
//   Self-checking bench: directed scenarios with literal expectations, then
//   randomized ATTACH/SKIP/READ/NOP traffic against a bit-level stream model.
// -----------------------------------------------------------------------------
module tb_madam_bitreader;
  import bitreader_pkg::*;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [31:0]   addr_in = '0;
  logic [31:0]   bitrate_in = '0;
  logic [31:0]   bitskip_in = '0;
  logic          req = 1'b0;
  bitreader_op_e op = BR_NOP;
  logic          ap_busy;
  logic [31:0]   data_out;

  always #5 aclk = ~aclk;

  mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem ();

  madam_bitreader #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .memory     (mem),
    .addr_in    (addr_in),
    .bitrate_in (bitrate_in),
    .bitskip_in (bitskip_in),
    .req        (req),
    .op         (op),
    .ap_busy    (ap_busy),
    .data_out   (data_out)
  );

  // ---------------- memory responder ----------------
  int gnt_delay = 0;
  int wait_cnt  = 0;
  bit inj_err   = 1'b0;
  logic [31:0] grants[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0027_1bd0: return 32'hd72b2ed6;
      32'h0027_1bd4: return 32'hcd72f74d;
      32'h0027_1bd8: return 32'h6ed65cb5;
      32'h0027_1bdc: return 32'hd6ba27de;
      default:       return 32'h0;
    endcase
  endfunction

  function automatic bit legal_addr(input logic [31:0] a);
    return (a == 32'h0) || (a >= 32'h0027_1bd0 && a <= 32'h0027_1bdc && a[1:0] == 2'b00);
  endfunction

  always_comb begin
    mem.gnt       = mem.req && (wait_cnt >= gnt_delay);
    mem.rsp_valid = 1'b1;
    mem.rsp_error = inj_err;
    mem.rsp_rdata = mem_word(mem.addr);
  end

  always @(posedge aclk) begin
    if (mem.req && !mem.gnt) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
    if (aresetn && mem.req && mem.gnt) grants.push_back(mem.addr);
  end

  always @(negedge aclk) begin
    if (aresetn && !legal_addr(mem.addr)) begin
      $display("FAIL illegal_addr: got %08h required one of 0 or 271bd0..271bdc", mem.addr);
      $fatal(1, "illegal memory address");
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Behavioural model state: stream origin, bit position, last READ result.
  logic [31:0] m_base = '0;
  logic [31:0] m_pos  = '0;
  logic [31:0] m_data = '0;
  bit          model_on = 1'b0;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr  = '0;

  // Per-cycle comparison whenever the outputs are meaningful (block idle),
  // plus address stability during a stalled request.
  always @(negedge aclk) begin
    if (aresetn && model_on) begin
      if (!ap_busy) begin
        check("data_out", data_out, m_data);
        check("idle_req", mem.req, 1'b0);
        check("idle_addr", mem.addr, 32'h0);
        check("idle_we_be", {mem.we, mem.be}, 5'h0F);
      end
      if (prev_stall) check("addr_hold", mem.addr, prev_addr);
      prev_stall <= mem.req && !mem.gnt;
      prev_addr  <= mem.addr;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  // Issue one op, update the model, and check busy length and fetch addresses.
  task automatic do_op(input bitreader_op_e o, input logic [31:0] a,
                       input logic [31:0] rate, input logic [31:0] skip, input bit err);
    int n;
    int exp_words;
    int exp_len;
    int cycles;
    logic [31:0] a0, a1, p, wa, w, val;
    @(posedge aclk); #1;
    op = o; addr_in = a; bitrate_in = rate; bitskip_in = skip;
    inj_err = err;
    grants.delete();
    req = 1'b1;
    @(posedge aclk); #1;
    req = 1'b0;
    exp_words = 0;
    n = 0;
    a0 = '0; a1 = '0;
    case (o)
      BR_ATTACH: begin
        m_base = a & 32'hFFFF_FFFC;
        m_pos  = (a % 4) * 8;
      end
      BR_SKIP: m_pos = m_pos + skip;
      BR_READ: begin
        n = (rate > 32) ? 32 : int'(rate);
        val = '0;
        for (int i = 0; i < n; i++) begin
          p   = m_pos + i;
          wa  = m_base + 4 * (p / 32);
          w   = err ? 32'h0 : mem_word(wa);
          val = {val[30:0], w[31 - int'(p % 32)]};
        end
        m_data = val;
        if (n > 0) begin
          a0 = m_base + 4 * (m_pos / 32);
          a1 = m_base + 4 * ((m_pos + n - 1) / 32);
          exp_words = (a1 != a0) ? 2 : 1;
        end
        m_pos = m_pos + n;
      end
      default: ;
    endcase
    exp_len = (exp_words == 0) ? 1 : exp_words * (2 + gnt_delay) + 1;
    cycles = 1;
    while (ap_busy && cycles < 200) begin
      @(posedge aclk); #1;
      cycles++;
    end
    check("busy_len", cycles - 1, exp_len);
    check("fetch_count", grants.size(), exp_words);
    if (exp_words >= 1 && grants.size() >= 1) check("fetch_addr0", grants[0], a0);
    if (exp_words == 2 && grants.size() >= 2) check("fetch_addr1", grants[1], a1);
    check("data_after_op", data_out, m_data);
    inj_err = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int abs_pos;
    int r;
    // Reset held for 16 cycles.
    repeat (16) @(posedge aclk);
    @(negedge aclk);
    check("rst_busy", ap_busy, 1'b0);
    check("rst_data", data_out, 32'h0);
    check("rst_req", mem.req, 1'b0);
    check("rst_addr", mem.addr, 32'h0);
    check("rst_we_be_wdata", {mem.we, mem.be, mem.wdata}, {1'b0, 4'hF, 32'h0});
    @(posedge aclk); #1;
    aresetn = 1'b1;
    model_on = 1'b1;

    // ATTACH then SKIP 0: one busy cycle each, no fetch, data stays 0.
    do_op(BR_ATTACH, 32'h0027_1bd0, 0, 0, 0);
    do_op(BR_SKIP, 0, 0, 0, 0);
    check("lit_data_still0", data_out, 32'h0);

    do_op(BR_READ, 0, 6, 0, 0);
    check("lit_read_35", data_out, 32'h35);
    do_op(BR_READ, 0, 6, 0, 0);
    check("lit_read_32", data_out, 32'h32);
    check("lit_bitpos12", m_pos, 32'd12);

    do_op(BR_SKIP, 0, 0, 18, 0);
    do_op(BR_READ, 0, 6, 0, 0);
    check("lit_cross_2c", data_out, 32'h2C);
    check("lit_cross_words", grants.size(), 2);
    if (grants.size() == 2) begin
      check("lit_cross_a0", grants[0], 32'h0027_1bd0);
      check("lit_cross_a1", grants[1], 32'h0027_1bd4);
    end
    do_op(BR_READ, 0, 6, 0, 0);
    check("lit_r35b", data_out, 32'h35);
    do_op(BR_READ, 0, 6, 0, 0);
    check("lit_r32b", data_out, 32'h32);
    do_op(BR_READ, 0, 6, 0, 0);
    check("lit_r3d", data_out, 32'h3D);

    // Zero-width read, full-word read, clamped width.
    do_op(BR_READ, 0, 0, 0, 0);
    check("lit_read0", data_out, 32'h0);
    do_op(BR_ATTACH, 32'h0027_1bd0, 0, 0, 0);
    do_op(BR_READ, 0, 32, 0, 0);
    check("lit_read32", data_out, 32'hd72b2ed6);
    do_op(BR_ATTACH, 32'h0027_1bd0, 0, 0, 0);
    do_op(BR_READ, 0, 40, 0, 0);
    check("lit_read40_clamp", data_out, 32'hd72b2ed6);

    // NOP: one busy cycle, data untouched.
    do_op(BR_NOP, 0, 0, 0, 0);
    check("lit_nop_hold", data_out, 32'hd72b2ed6);

    // Delayed grant: same results, address held while stalled.
    gnt_delay = 3;
    do_op(BR_ATTACH, 32'h0027_1bd0, 0, 0, 0);
    do_op(BR_READ, 0, 6, 0, 0);
    check("lit_gd_35", data_out, 32'h35);
    do_op(BR_READ, 0, 6, 0, 0);
    do_op(BR_SKIP, 0, 0, 18, 0);
    do_op(BR_READ, 0, 6, 0, 0);
    check("lit_gd_2c", data_out, 32'h2C);
    gnt_delay = 0;

    // Error response: word taken as zero.
    do_op(BR_ATTACH, 32'h0027_1bd0, 0, 0, 0);
    do_op(BR_READ, 0, 8, 0, 1);
    check("lit_err_zero", data_out, 32'h0);

    // Bit position wraps modulo 2^32.
    do_op(BR_ATTACH, 32'h0027_1bd0, 0, 0, 0);
    do_op(BR_SKIP, 0, 0, 32'hFFFF_FFF0, 0);
    do_op(BR_SKIP, 0, 0, 32'd16, 0);
    do_op(BR_READ, 0, 6, 0, 0);
    check("lit_wrap_35", data_out, 32'h35);

    // Byte-offset attach.
    do_op(BR_ATTACH, 32'h0027_1bd5, 0, 0, 0);
    do_op(BR_READ, 0, 8, 0, 0);
    check("lit_attach_off", data_out, 32'h72);

    // Randomized traffic kept inside the four known words.
    for (int i = 0; i < 80; i++) begin
      gnt_delay = $urandom_range(2, 0);
      abs_pos = int'(m_base - 32'h0027_1bd0) * 8 + int'(m_pos);
      r = $urandom_range(9, 0);
      if (i == 0 || r < 2 || abs_pos < 0 || abs_pos > 96)
        do_op(BR_ATTACH, 32'h0027_1bd0 + $urandom_range(7, 0), 0, 0, 0);
      else if (r < 4)
        do_op(BR_SKIP, 0, 0, $urandom_range(96 - abs_pos, 0), 0);
      else if (r == 4)
        do_op(BR_NOP, 0, 0, 0, 0);
      else
        do_op(BR_READ, 0, $urandom_range(40, 0), 0, ($urandom_range(9, 0) == 0));
    end

    // Reset in the middle of a stalled READ.
    gnt_delay = 10;
    do_op(BR_ATTACH, 32'h0027_1bd0, 0, 0, 0);
    @(posedge aclk); #1;
    op = BR_READ; bitrate_in = 6; req = 1'b1;
    @(posedge aclk); #1;
    req = 1'b0;
    repeat (3) @(posedge aclk);
    #3;
    check("midrd_busy_before", ap_busy, 1'b1);
    aresetn = 1'b0;
    #1;
    check("midrst_busy", ap_busy, 1'b0);
    check("midrst_req", mem.req, 1'b0);
    check("midrst_addr", mem.addr, 32'h0);
    check("midrst_data", data_out, 32'h0);
    m_base = '0; m_pos = '0; m_data = '0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    gnt_delay = 0;
    do_op(BR_ATTACH, 32'h0027_1bd0, 0, 0, 0);
    do_op(BR_READ, 0, 6, 0, 0);
    check("lit_after_rst_35", data_out, 32'h35);

    repeat (2) @(posedge aclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish required finish before 1ms");
    $fatal(1, "timeout");
  end

endmodule
